ixc_assign_pipe: RTL and testbench
==================================

# ixc_assign_pipe

Parametrised, registered successor to the fixed-width bitwise assign templates in the IXCOM template library. It carries a WIDTH-bit bus from R to L through a DEPTH-stage pipeline with a valid qualifier, a global freeze (stall), and a per-bit force overlay for emulation debug. A saturating change counter records how often the delivered value changes. It is instantiated wherever the emulation netlist needs a retimed, observable, forceable bus assign in place of a plain combinational one.

## Interface
- WIDTH, 26, bus width in bits (1..1024).
- DEPTH, 2, pipeline stages (0..8); 0 = combinational pass-through.
- RESET_VAL, {WIDTH{1'b0}}, reset value of every data stage and of L.
- CNT_W, 16, change-counter width (2..32).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- R  input  WIDTH  source data.
- R_vld  input  1  R is valid this cycle.
- freeze  input  1  hold all pipeline stages and valids.
- force_load  input  1  strobe: capture force_mask/force_val.
- force_mask  input  WIDTH  bits to force (1 = forced).
- force_val  input  WIDTH  forced bit values.
- cnt_clr  input  1  synchronous clear of chg_cnt.
- L  output  WIDTH  delivered data, with force overlay.
- L_vld  output  1  L is valid.
- chg_cnt  output  CNT_W  saturating count of valid-output value changes.

## Operation
- Pipeline: stage[0] <= R, vld[0] <= R_vld; stage[i] <= stage[i-1], vld[i] <= vld[i-1]. Data stages load every unfrozen cycle regardless of valid (bubbles carry data with vld=0).
- freeze=1: no stage or vld bit changes; L/L_vld hold. Input on R during freeze is dropped.
- Raw output P = stage[DEPTH-1], Pv = vld[DEPTH-1]; DEPTH=0: P = R, Pv = R_vld, freeze has no effect on data.
- Force: on force_load, mask_q <= force_mask, fval_q <= force_val (applies even while frozen). L = (P & ~mask_q) | (fval_q & mask_q). L_vld = Pv (force does not alter valid). Release = force_load with force_mask = 0.
- Change counter: last_q holds the last raw P delivered with Pv=1 (unforced value). On a clock with Pv=1, freeze=0 (or DEPTH=0), and P != last_q: chg_cnt increments, saturating at all-ones; last_q <= P. If Pv=1 and P == last_q, no increment.
- cnt_clr=1: chg_cnt <= 0 and wins over a simultaneous increment; last_q is still updated.
- Forced bits never contribute to change detection.

## Timing
- Reset (rst_n=0, immediate): all stages = RESET_VAL, all vld = 0, mask_q = 0, fval_q = 0, last_q = RESET_VAL, chg_cnt = 0. Hence L = RESET_VAL, L_vld = 0 (DEPTH≥1); DEPTH=0: L = R, L_vld = R_vld combinationally.
- Reset mid-stream discards all in-flight data; first valid out appears DEPTH cycles after the first valid R sampled following release.
- Latency: R sampled at edge n appears on L after edge n+DEPTH-1 (i.e. visible in cycle n+DEPTH), plus one cycle per frozen cycle in between.
- Force overlay: takes effect in the cycle after the force_load edge; combinational on P thereafter.
- chg_cnt updates on the edge that samples the qualifying Pv; visible next cycle.
- Throughput: one word per unfrozen cycle; no backpressure other than freeze.

## Test plan
- Reset/latency: WIDTH=26, DEPTH=2; release reset, drive R=0x3FFFFFF, R_vld=1 for one cycle -> L=0 and L_vld=0 for 1 cycle, then L=0x3FFFFFF, L_vld=1 for exactly one cycle.
- Freeze: stream 1,2,3,4 with freeze=1 on the cycle 2 is in stage 0 -> output sequence 1,2,3,4 each valid once, output stalled one extra cycle, value sampled on R during freeze absent.
- Force/release: force_load with mask=0x00000FF, val=0x0000055 while streaming 0x3FFFF00 -> L=0x3FFFF55; release with mask=0 -> L=0x3FFFF00 next cycle; chg_cnt unchanged by force.
- Counter: send valid 5,5,7,7,5 -> chg_cnt=2 after 5→7→5 (first 5 vs RESET_VAL 0 counts: total 3); CNT_W=2 with 6 changes -> saturates at 3; cnt_clr with simultaneous change -> 0.
- DEPTH=0: R=0x1234567, R_vld=1, freeze=1 -> L=0x1234567, L_vld=1 same cycle.
- Async reset mid-stream with pipeline full -> L=RESET_VAL, L_vld=0, chg_cnt=0 without a clock edge.

Source files
------------

// File: rtl/ixc_assign_pipe.sv
// ixc_assign_pipe: retimed, freezable, forceable bus assign R -> L.
// A DEPTH-stage register pipeline with a valid qualifier, a global freeze,
// a per-bit force overlay on the output, and a saturating counter of how
// often the delivered (unforced) value changes.
`timescale 1ns/1ps

module ixc_assign_pipe #(
    parameter int               WIDTH     = 26,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R,
    input  logic             R_vld,
    input  logic             freeze,
    input  logic             force_load,
    input  logic [WIDTH-1:0] force_mask,
    input  logic [WIDTH-1:0] force_val,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] L,
    output logic             L_vld,
    output logic [CNT_W-1:0] chg_cnt
);

    // Raw pipeline output and its qualifier, plus "this edge delivers P".
    logic [WIDTH-1:0] w_p;
    logic             w_pv;
    logic             w_adv;

    generate
        if (DEPTH == 0) begin : g_comb
            // No registers: the bus passes straight through and freeze is
            // irrelevant to the data path, so every edge delivers P.
            assign w_p   = R;
            assign w_pv  = R_vld;
            assign w_adv = 1'b1;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] r_stage;
            logic [DEPTH-1:0]            r_vld;

            // Shift data and valids one stage per unfrozen cycle; bubbles
            // still move their data so the stages never need a data enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= {DEPTH{RESET_VAL}};
                    r_vld   <= '0;
                end else if (!freeze) begin
                    r_stage[0] <= R;
                    r_vld[0]   <= R_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                        r_vld[i]   <= r_vld[i-1];
                    end
                end
            end

            assign w_p   = r_stage[DEPTH-1];
            assign w_pv  = r_vld[DEPTH-1];
            assign w_adv = !freeze;
        end
    endgenerate

    // Force overlay state.
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_fval;

    // Capture the force overlay on its strobe; deliberately not gated by
    // freeze so a stalled design can still be forced from the debugger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
            r_fval <= '0;
        end else if (force_load) begin
            r_mask <= force_mask;
            r_fval <= force_val;
        end
    end

    assign L     = (w_p & ~r_mask) | (r_fval & r_mask);
    assign L_vld = w_pv;

    // Change detection works on the raw P, so the overlay never counts.
    logic [WIDTH-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             w_dlv;
    logic             w_chg;
    logic             w_sat;

    assign w_dlv = w_pv && w_adv;
    assign w_chg = w_dlv && (w_p != r_last);
    assign w_sat = &r_cnt;

    // Remember the last delivered raw value; updated even during a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= RESET_VAL;
        end else if (w_chg) begin
            r_last <= w_p;
        end
    end

    // Saturating change counter; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_chg && !w_sat) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign chg_cnt = r_cnt;

endmodule

// File: tb/tb_ixc_assign_pipe.sv
// Bench for ixc_assign_pipe: main DUT (DEPTH=2), a CNT_W=2 instance for
// saturation and a DEPTH=0 instance for pass-through, all on shared inputs.
`timescale 1ns/1ps

module tb_ixc_assign_pipe;
    localparam int W = 26;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] R = '0;
    logic         R_vld = 1'b0;
    logic         freeze = 1'b0;
    logic         force_load = 1'b0;
    logic [W-1:0] force_mask = '0;
    logic [W-1:0] force_val = '0;
    logic         cnt_clr = 1'b0;

    logic [W-1:0] L, Ls, L0;
    logic         L_vld, Ls_vld, L0_vld;
    logic [15:0]  chg, chg0;
    logic [1:0]   chgs;

    ixc_assign_pipe #(.WIDTH(W), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .R(R), .R_vld(R_vld), .freeze(freeze),
        .force_load(force_load), .force_mask(force_mask), .force_val(force_val),
        .cnt_clr(cnt_clr), .L(L), .L_vld(L_vld), .chg_cnt(chg));

    ixc_assign_pipe #(.WIDTH(W), .DEPTH(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .R(R), .R_vld(R_vld), .freeze(freeze),
        .force_load(force_load), .force_mask(force_mask), .force_val(force_val),
        .cnt_clr(cnt_clr), .L(Ls), .L_vld(Ls_vld), .chg_cnt(chgs));

    ixc_assign_pipe #(.WIDTH(W), .DEPTH(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .R(R), .R_vld(R_vld), .freeze(freeze),
        .force_load(force_load), .force_mask(force_mask), .force_val(force_val),
        .cnt_clr(cnt_clr), .L(L0), .L_vld(L0_vld), .chg_cnt(chg0));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: raw words accepted by the pipeline, plus the force state.
    logic [W-1:0] q[$];
    logic [W-1:0] m_mod = '0;
    logic [W-1:0] v_mod = '0;
    logic         last_frz = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_mod    = '0;
            v_mod    = '0;
            last_frz = 1'b1;
        end else begin
            if (R_vld && !freeze) q.push_back(R);
            if (force_load) begin
                m_mod = force_mask;
                v_mod = force_val;
            end
            last_frz = freeze;
        end
    end

    // Monitor: a new word is presented after every unfrozen edge with L_vld.
    always @(negedge clk) begin
        if (rst_n && L_vld && !last_frz) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got L=%h, expected no valid output", L);
            end else begin
                logic [W-1:0] raw, exp;
                raw = q.pop_front();
                exp = (raw & ~m_mod) | (v_mod & m_mod);
                if (L !== exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got L=%h, expected %h", L, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [W-1:0] r, input logic v, input logic f);
        R = r; R_vld = v; freeze = f;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_L", L, 0);
        check("rst_Lvld", L_vld, 0);
        check("rst_cnt", chg, 0);
        check("rst_cnt_s", chgs, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Latency: one valid word through DEPTH=2
        cyc(26'h3FFFFFF, 1'b1, 1'b0);
        check("lat_L_first", L, 0);
        check("lat_vld_first", L_vld, 0);
        cyc('0, 1'b0, 1'b0);
        check("lat_L_out", L, 32'h3FFFFFF);
        cyc('0, 1'b0, 1'b0);
        check("lat_vld_once", L_vld, 0);
        check("lat_cnt", chg, 1);
        check("lat_cnt_s", chgs, 1);

        // Freeze: word sampled during freeze is dropped, output holds
        cyc(26'd1, 1'b1, 1'b0);
        cyc(26'd2, 1'b1, 1'b0);
        cyc(26'h99, 1'b1, 1'b1);
        check("frz_hold_L", L, 1);
        check("frz_hold_vld", L_vld, 1);
        cyc(26'd3, 1'b1, 1'b0);
        cyc(26'd4, 1'b1, 1'b0);
        idle(3);
        check("frz_cnt", chg, 5);
        check("sat_cnt_s", chgs, 3);

        // Force and release while streaming a constant
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        force_load = 1'b1; force_mask = 26'h00000FF; force_val = 26'h0000055;
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        force_load = 1'b0;
        check("force_L", L, 32'h3FFFF55);
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        force_load = 1'b1; force_mask = '0; force_val = '0;
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        force_load = 1'b0;
        check("release_L", L, 32'h3FFFF00);
        cyc(26'h3FFFF00, 1'b1, 1'b0);
        idle(3);
        check("force_cnt", chg, 6);

        // Async reset mid-stream with the pipeline full
        cyc(26'h111, 1'b1, 1'b0);
        cyc(26'h222, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_L", L, 0);
        check("arst_vld", L_vld, 0);
        check("arst_cnt", chg, 0);
        check("arst_cnt_s", chgs, 0);
        R_vld = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Counter: 5,5,7,7,5 -> three changes (first 5 vs reset value)
        cyc(26'd5, 1'b1, 1'b0);
        cyc(26'd5, 1'b1, 1'b0);
        cyc(26'd7, 1'b1, 1'b0);
        cyc(26'd7, 1'b1, 1'b0);
        cyc(26'd5, 1'b1, 1'b0);
        idle(3);
        check("cnt_seq", chg, 3);
        check("cnt_seq_s", chgs, 3);

        // Clear coincident with a change; last value still captured
        cyc(26'd9, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        cnt_clr = 1'b1;
        cyc('0, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        check("clr_win", chg, 0);
        check("clr_win_s", chgs, 0);
        cyc(26'd9, 1'b1, 1'b0);
        idle(3);
        check("clr_last", chg, 0);

        // DEPTH=0 pass-through ignores freeze
        R = 26'h1234567; R_vld = 1'b1; freeze = 1'b1;
        #1;
        check("d0_L", L0, 32'h1234567);
        check("d0_vld", L0_vld, 1);
        R_vld = 1'b0;
        #1;
        check("d0_novld", L0_vld, 0);
        cyc(26'h1234567, 1'b1, 1'b1);
        idle(4);

        check("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
